// File: rtl/router_fsm.sv
// router_fsm: control state machine for the 1x3 router.
// Decodes the header address, sequences header/payload/parity loading through
// the register stage, stalls on a full FIFO and raises busy to hold off the source.
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    WAIT_TILL_EMPTY    = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_e;

  state_e     r_state;
  state_e     w_next;
  logic [1:0] r_addr;
  logic       w_hdr_valid;
  logic       w_empty_hdr;
  logic       w_empty_addr;
  logic       w_soft_rst;

  // A header is accepted only when the source presents it with a legal address.
  assign w_hdr_valid = pkt_valid && (data_in != 2'd3);

  // Select the empty flag of the port named by the live header and by the latched address,
  // and detect a timeout reset that targets the port this packet is bound for.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_empty_hdr  = 1'b0;
    w_empty_addr = 1'b0;
    w_soft_rst   = 1'b0;
    case (data_in)
      2'd0:    w_empty_hdr = fifo_empty_0;
      2'd1:    w_empty_hdr = fifo_empty_1;
      2'd2:    w_empty_hdr = fifo_empty_2;
      default: w_empty_hdr = 1'b0;
    endcase
    case (r_addr)
      2'd0: begin
        w_empty_addr = fifo_empty_0;
        w_soft_rst   = soft_reset_0;
      end
      2'd1: begin
        w_empty_addr = fifo_empty_1;
        w_soft_rst   = soft_reset_1;
      end
      2'd2: begin
        w_empty_addr = fifo_empty_2;
        w_soft_rst   = soft_reset_2;
      end
      default: begin
        w_empty_addr = 1'b0;
        w_soft_rst   = 1'b0;
      end
    endcase
  end

  // State register and destination-address latch.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= DECODE_ADDRESS;
      r_addr  <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= w_next;
      if (r_state == DECODE_ADDRESS && w_hdr_valid) begin
        r_addr <= data_in;
      end
    end
  end

  // Next-state decode; a matching soft reset overrides every transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      DECODE_ADDRESS: begin
        if (w_hdr_valid) begin
          w_next = w_empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: w_next = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full) begin
          w_next = FIFO_FULL_STATE;
        end else if (!pkt_valid) begin
          w_next = LOAD_PARITY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (w_empty_addr) begin
          w_next = LOAD_FIRST_DATA;
        end
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) begin
          w_next = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        if (parity_done) begin
          w_next = DECODE_ADDRESS;
        end else if (low_pkt_valid) begin
          w_next = LOAD_PARITY;
        end else begin
          w_next = LOAD_DATA;
        end
      end
      LOAD_PARITY: w_next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      default: w_next = DECODE_ADDRESS;
    endcase
    if (w_soft_rst) begin
      w_next = DECODE_ADDRESS;
    end
  end

  // Moore outputs: pure decodes of the state register.
  assign detect_add    = (r_state == DECODE_ADDRESS);
  assign lfd_state     = (r_state == LOAD_FIRST_DATA);
  assign ld_state      = (r_state == LOAD_DATA);
  assign laf_state     = (r_state == LOAD_AFTER_FULL);
  assign full_state    = (r_state == FIFO_FULL_STATE);
  assign rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
  assign write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                         (r_state == LOAD_AFTER_FULL);
  assign busy          = (r_state != DECODE_ADDRESS) && (r_state != LOAD_DATA);

endmodule
